// File: rtl/mem_store_buffer_if.sv
// rtl/mem_store_buffer_if.sv - store buffer pipeline/memory handshake bundle
interface mem_store_buffer_if #(
    parameter int WORD_LEN = 32
);
    logic                st_valid;
    logic [WORD_LEN-1:0] st_address;
    logic [WORD_LEN-1:0] st_data;
    logic                st_ready;
    logic                ld_valid;
    logic [WORD_LEN-1:0] ld_address;
    logic                ld_hit;
    logic [WORD_LEN-1:0] ld_data;
    logic                flush;
    logic                flush_done;
    logic                mem_writeEn;
    logic [WORD_LEN-1:0] mem_address;
    logic [WORD_LEN-1:0] mem_dataIn;

    modport master (
        output st_valid, st_address, st_data, ld_valid, ld_address, flush,
        input  st_ready, ld_hit, ld_data, flush_done, mem_writeEn, mem_address, mem_dataIn
    );

    modport slave (
        input  st_valid, st_address, st_data, ld_valid, ld_address, flush,
        output st_ready, ld_hit, ld_data, flush_done, mem_writeEn, mem_address, mem_dataIn
    );
endinterface

// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - posted-write FIFO between MEM stage and data memory
// Retires stores when the memory port is free and forwards the youngest match to loads.
module mem_store_buffer #(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 4,
    parameter int PTR_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_store_buffer_if.slave  bus
);
    localparam logic [PTR_W:0] L_DEPTH = DEPTH[PTR_W:0];

    logic [WORD_LEN-1:0] r_addr [DEPTH];
    logic [WORD_LEN-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [PTR_W:0]      r_count;

    logic                w_enq;
    logic                w_drain;
    logic                w_hit;
    logic [WORD_LEN-1:0] w_fwd;
    logic [PTR_W-1:0]    w_slot [DEPTH];

    assign bus.st_ready    = (r_count != L_DEPTH) && !bus.flush;
    assign w_enq           = bus.st_valid && bus.st_ready;
    assign w_drain         = (r_count != '0) && (!bus.ld_valid || bus.flush);
    assign bus.flush_done  = (r_count == '0);
    assign bus.mem_writeEn = w_drain;
    assign bus.mem_address = w_drain ? r_addr[r_head] : '0;
    assign bus.mem_dataIn  = w_drain ? r_data[r_head] : '0;
    assign bus.ld_hit      = w_hit;
    assign bus.ld_data     = w_fwd;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot[i] = r_head + PTR_W'(i);
            if (((PTR_W+1)'(i) < r_count) &&
                (r_addr[w_slot[i]][WORD_LEN-1:1] == bus.ld_address[WORD_LEN-1:1])) begin
                w_hit = 1'b1;
                w_fwd = r_data[w_slot[i]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                r_addr[r_tail] <= bus.st_address;
                r_data[r_tail] <= bus.st_data;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_store_buffer.sv
// tb/tb_mem_store_buffer.sv - directed vector bench for mem_store_buffer
module tb_mem_store_buffer;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mem_store_buffer_if #(.WORD_LEN(32)) bus ();

    mem_store_buffer #(.WORD_LEN(32), .DEPTH(4), .PTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
        logic        fl;
        logic        e_rdy;
        logic        e_hit;
        logic [31:0] e_ldd;
        logic        e_wen;
        logic [31:0] e_ma;
        logic [31:0] e_md;
        logic        e_fd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic sv, logic [31:0] sa, logic [31:0] sd, logic lv,
                                logic [31:0] la, logic fl, logic e_rdy, logic e_hit,
                                logic [31:0] e_ldd, logic e_wen, logic [31:0] e_ma,
                                logic [31:0] e_md, logic e_fd);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la; v.fl = fl;
        v.e_rdy = e_rdy; v.e_hit = e_hit; v.e_ldd = e_ldd; v.e_wen = e_wen;
        v.e_ma = e_ma; v.e_md = e_md; v.e_fd = e_fd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(logic sv, logic [31:0] sa, logic [31:0] sd, logic lv,
                         logic [31:0] la, logic fl);
        bus.st_valid   = sv;
        bus.st_address = sa;
        bus.st_data    = sd;
        bus.ld_valid   = lv;
        bus.ld_address = la;
        bus.flush      = fl;
    endtask

    task automatic chk_all(string tag, logic rdy, logic hit, logic [31:0] ldd, logic wen,
                           logic [31:0] ma, logic [31:0] md, logic fd);
        chk({tag, ".st_ready"},    32'(bus.st_ready),    32'(rdy));
        chk({tag, ".ld_hit"},      32'(bus.ld_hit),      32'(hit));
        chk({tag, ".ld_data"},     bus.ld_data,          ldd);
        chk({tag, ".mem_writeEn"}, 32'(bus.mem_writeEn), 32'(wen));
        chk({tag, ".mem_address"}, bus.mem_address,      ma);
        chk({tag, ".mem_dataIn"},  bus.mem_dataIn,       md);
        chk({tag, ".flush_done"},  32'(bus.flush_done),  32'(fd));
    endtask

    localparam logic [31:0] NA = 32'h100;

    initial begin
        // idle and single store
        vq.push_back(mk(0, 0, 0, 0, 0, 0,                    1, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 32'h20, 32'hDEADBEEF, 0, 0, 0,    1, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,                    1, 0, 0, 1, 32'h20, 32'hDEADBEEF, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,                    1, 0, 0, 0, 0, 0, 1));
        // fill under continuous loads, fifth store refused
        vq.push_back(mk(1, 32'h00, 32'hA0, 1, NA, 0,         1, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 32'h04, 32'hA1, 1, NA, 0,         1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h08, 32'hA2, 1, NA, 0,         1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h0C, 32'hA3, 1, NA, 0,         1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h10, 32'hA4, 1, NA, 0,         0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 32'h09, 0,               0, 1, 32'hA2, 0, 0, 0, 0));
        // drain in FIFO order
        vq.push_back(mk(0, 0, 0, 0, NA, 0,                   0, 0, 0, 1, 32'h00, 32'hA0, 0));
        vq.push_back(mk(0, 0, 0, 0, NA, 0,                   1, 0, 0, 1, 32'h04, 32'hA1, 0));
        vq.push_back(mk(0, 0, 0, 0, NA, 0,                   1, 0, 0, 1, 32'h08, 32'hA2, 0));
        vq.push_back(mk(0, 0, 0, 0, NA, 0,                   1, 0, 0, 1, 32'h0C, 32'hA3, 0));
        vq.push_back(mk(0, 0, 0, 0, NA, 0,                   1, 0, 0, 0, 0, 0, 1));
        // forwarding of youngest match, same-cycle store invisible
        vq.push_back(mk(1, 32'h40, 32'h1, 1, 32'h41, 0,      1, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 32'h40, 32'h2, 1, 32'h41, 0,      1, 1, 32'h1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 32'h41, 0,               1, 1, 32'h2, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 32'h44, 0,               1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h40, 0,               1, 1, 32'h2, 1, 32'h40, 32'h1, 0));
        vq.push_back(mk(0, 0, 0, 1, 32'h40, 0,               1, 1, 32'h2, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, NA, 0,                   1, 0, 0, 1, 32'h40, 32'h2, 0));
        // flush with loads active and a store being refused
        vq.push_back(mk(1, 32'h50, 32'hB0, 1, NA, 0,         1, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 32'h54, 32'hB1, 1, NA, 0,         1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h58, 32'hB2, 1, NA, 0,         1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h5C, 32'hB3, 1, NA, 1,         0, 0, 0, 1, 32'h50, 32'hB0, 0));
        vq.push_back(mk(1, 32'h5C, 32'hB3, 1, NA, 1,         0, 0, 0, 1, 32'h54, 32'hB1, 0));
        vq.push_back(mk(1, 32'h5C, 32'hB3, 1, NA, 1,         0, 0, 0, 1, 32'h58, 32'hB2, 0));
        vq.push_back(mk(0, 0, 0, 1, NA, 1,                   0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, NA, 0,                   1, 0, 0, 0, 0, 0, 1));

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_all("reset", 1, 0, 0, 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vq[k]) begin
            drive(vq[k].sv, vq[k].sa, vq[k].sd, vq[k].lv, vq[k].la, vq[k].fl);
            #1;
            chk_all($sformatf("vec%0d", k), vq[k].e_rdy, vq[k].e_hit, vq[k].e_ldd,
                    vq[k].e_wen, vq[k].e_ma, vq[k].e_md, vq[k].e_fd);
            @(negedge clk);
        end

        // asynchronous reset with two stores pending
        drive(1, 32'h60, 32'hC0, 1, NA, 0);
        @(negedge clk);
        drive(1, 32'h64, 32'hC1, 1, NA, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h60, 0);
        #1;
        chk_all("pre_rst", 1, 1, 32'hC0, 1, 32'h60, 32'hC0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("mid_rst", 1, 0, 0, 0, 0, 0, 1);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk_all($sformatf("post_rst%0d", c), 1, 0, 0, 0, 0, 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Posted-write FIFO between the MEM pipeline stage and the data memory.
- Accepts stores from the MEM stage in one cycle, holds up to DEPTH of them, and retires them to the data memory write port in cycles when no load uses the memory port.
- Loads whose address matches a buffered store get the youngest matching store's data forwarded, so memory ordering is preserved without stalling the pipeline on every store.

Parameters:
- WORD_LEN, 32, data and address width in bits.
- DEPTH, 4, number of buffer entries; power of two, minimum 2.
- PTR_W, 2, pointer width, log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- st_valid  input  1  MEM stage presents a store this cycle.
- st_address  input  WORD_LEN  store byte address.
- st_data  input  WORD_LEN  store data.
- st_ready  output  1  buffer can accept a store this cycle; 0 stalls the pipeline.
- ld_valid  input  1  MEM stage performs a load this cycle; occupies the memory port.
- ld_address  input  WORD_LEN  load byte address.
- ld_hit  output  1  a buffered store matches ld_address.
- ld_data  output  WORD_LEN  forwarded data when ld_hit=1, else 0.
- flush  input  1  force drain (pipeline flush, halt).
- flush_done  output  1  buffer empty.
- mem_writeEn  output  1  write strobe to the data memory.
- mem_address  output  WORD_LEN  write address to the data memory.
- mem_dataIn  output  WORD_LEN  write data to the data memory.

Behaviour:
- Storage:
  - DEPTH entries of {address, data}.
  - Head pointer, tail pointer, and count (PTR_W+1 bits) are registered.
  - Pointers wrap modulo DEPTH.
- Reset (asynchronous, rst=1):
  - count=0, head=tail=0, all entry fields 0.
  - Outputs immediately: st_ready=1, ld_hit=0, ld_data=0, mem_writeEn=0, mem_address=0, mem_dataIn=0, flush_done=1.
- Address matching:
  - Compare addresses with bit 0 cleared, i.e. (addr>>1)<<1, matching the memory's even-base word addressing.
  - Addresses 0x11 and 0x10 are equal.
- Enqueue:
  - st_ready = (count != DEPTH) && !flush, derived from registered state only.
  - If st_valid && st_ready, the entry at tail is written and tail increments at the clock edge.
  - If st_valid && !st_ready, nothing is stored; the MEM stage holds the store.
  - No merging: a repeat store to a buffered address takes a new entry.
- Drain:
  - drain = (count != 0) && (!ld_valid || flush).
  - mem_writeEn = drain. mem_address and mem_dataIn = head entry, combinational from registers.
  - When mem_writeEn=0, mem_address and mem_dataIn read 0.
  - On the clock edge with drain=1, head increments; the memory captures the write on the same edge.
- Simultaneous enqueue and drain: count unchanged, both pointers advance.
  - A full buffer does not accept a store in the cycle it drains; st_ready depends on the registered count only, with no bypass.
- Forwarding (combinational):
  - Search all valid entries (the count entries starting at head) for an address match.
  - ld_hit=1 if any entry matches. ld_data = data of the youngest match, i.e. the one nearest tail.
  - A store enqueuing in the same cycle is not visible to the load; the hazard unit orders this case.
  - ld_hit and ld_data are evaluated regardless of ld_valid.
  - An entry draining this cycle still forwards this cycle.
- Flush:
  - While flush=1, stores are refused and one entry retires per cycle even if ld_valid=1.
  - flush_done = (count == 0).
- Latency:
  - A store is visible in memory at the earliest 1 edge after enqueue (enqueue edge, then drain edge).
  - The worst case under continuous loads is unbounded until flush.
- Reset mid-operation: all buffered stores are discarded with no memory write. mem_writeEn drops asynchronously.

Test Plan:
- Reset, then idle → st_ready=1, flush_done=1, mem_writeEn=0, ld_hit=0.
- Store 0x20←0xDEADBEEF with ld_valid=0 → next cycle mem_writeEn=1, mem_address=0x20, mem_dataIn=0xDEADBEEF; following cycle flush_done=1.
- Hold ld_valid=1 and issue 5 stores to 0x00, 0x04, 0x08, 0x0C, 0x10 → first 4 accepted; st_ready=0 on the 5th with count=4; mem_writeEn stays 0; drop ld_valid → 4 writes in FIFO order over 4 cycles.
- With ld_valid=1, store 0x40←1 then 0x40←2, then load 0x41 → ld_hit=1, ld_data=2; load 0x44 → ld_hit=0, ld_data=0.
- With 3 entries buffered and ld_valid=1, assert flush → 3 consecutive drain cycles, st_ready=0 throughout, then flush_done=1.
- With 2 entries buffered, pulse rst between clock edges → mem_writeEn=0 immediately; no memory write after release; count=0.
